// File: rtl/fetch_aligner_if.sv
// rtl/fetch_aligner_if.sv - memory fetch, instruction delivery and redirect signals of fetch_aligner
interface fetch_aligner_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_c;
    logic        redirect;
    logic [31:0] redirect_pc;

    // Aligner side: issues fetches, presents instructions.
    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_valid,
        input  fetch_data,
        output inst_valid,
        input  inst_ready,
        output inst_out,
        output inst_pc,
        output inst_c,
        input  redirect,
        input  redirect_pc
    );

    // Environment side: instruction memory, decode stage and branch unit.
    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_valid,
        output fetch_data,
        input  inst_valid,
        output inst_ready,
        input  inst_out,
        input  inst_pc,
        input  inst_c,
        output redirect,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_aligner.sv
// rtl/fetch_aligner.sv - word fetch front end emitting aligned 32-bit and 16-bit compressed instructions
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BUF_HW   = 4
) (
    input  logic            risc_clk,
    input  logic            rst,
    fetch_aligner_if.master bus
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [2:0]  BUF_MAX  = 3'(BUF_HW);

    // Halfword buffer, entry 0 is the head (oldest halfword).
    logic [BUF_HW-1:0][15:0] buf_q, buf_d;
    logic [2:0]              occ_q, occ_d;
    logic [31:0]             pc_q, pc_d;
    logic [31:0]             addr_q, addr_d;
    logic                    outst_q, outst_d;
    logic                    discard_q, discard_d;
    logic                    skip_low_q, skip_low_d;

    logic                    head_c;
    logic                    inst_valid;
    logic                    consume;
    logic                    resp;
    logic                    append;
    logic                    req;
    logic [2:0]              pop_n;
    logic [2:0]              app_n;
    logic [2:0]              occ_c;
    logic [2:0]              occ_n;
    logic [15:0]             app_lo;
    logic [15:0]             app_hi;
    logic [BUF_HW-1:0][15:0] shifted;

    // Decode the head of the buffer into the instruction currently offered downstream.
    always_comb begin
        head_c     = buf_q[0][1:0] != 2'b11;
        inst_valid = ((occ_q >= 3'd1) && head_c) || (occ_q >= 3'd2);
        pop_n      = head_c ? 3'd1 : 3'd2;
        consume    = inst_valid && bus.inst_ready;
    end

    // Memory response handling and the one-outstanding fetch throttle.
    always_comb begin
        resp   = bus.fetch_valid && outst_q;
        append = resp && !discard_q && !bus.redirect;
        if (!append) begin
            app_n = 3'd0;
        end else if (skip_low_q) begin
            app_n = 3'd1;
        end else begin
            app_n = 3'd2;
        end
        app_lo = skip_low_q ? bus.fetch_data[31:16] : bus.fetch_data[15:0];
        app_hi = bus.fetch_data[31:16];
        occ_c  = consume ? (occ_q - pop_n) : occ_q;
        occ_n  = occ_c + app_n;
        // A request may go out in the same cycle the previous response lands,
        // which is what keeps 32-bit code at one instruction per cycle. Counting
        // this cycle's append keeps the buffer from ever exceeding its depth.
        req    = !rst && !bus.redirect && !discard_q && !(outst_q && !resp)
                 && (occ_n <= 3'd2);
    end

    // Next-state: redirect wins over consume and append.
    always_comb begin
        shifted = buf_q;
        if (consume) begin
            shifted = head_c ? (buf_q >> 16) : (buf_q >> 32);
        end
        buf_d = shifted;
        for (int i = 0; i < BUF_HW; i++) begin
            if ((app_n != 3'd0) && (occ_c == 3'(i))) begin
                buf_d[i] = app_lo;
            end
            if ((app_n == 3'd2) && ((occ_c + 3'd1) == 3'(i))) begin
                buf_d[i] = app_hi;
            end
        end

        occ_d      = occ_n;
        pc_d       = consume ? (pc_q + (head_c ? 32'd2 : 32'd4)) : pc_q;
        addr_d     = req ? (addr_q + 32'd4) : addr_q;
        skip_low_d = append ? 1'b0 : skip_low_q;
        outst_d    = (outst_q && !resp) || req;
        discard_d  = discard_q && !resp;

        if (bus.redirect) begin
            buf_d      = '0;
            occ_d      = 3'd0;
            pc_d       = bus.redirect_pc & ~32'h1;
            addr_d     = bus.redirect_pc & ~32'h3;
            skip_low_d = bus.redirect_pc[1];
            // A response still in flight belongs to the old path and must be dropped.
            outst_d    = outst_q && !resp;
            discard_d  = outst_q && !resp;
        end
    end

    // State registers.
    always_ff @(posedge risc_clk or posedge rst) begin
        if (rst) begin
            buf_q      <= '0;
            occ_q      <= 3'd0;
            pc_q       <= RESET_PC & ~32'h1;
            addr_q     <= RESET_PC & ~32'h3;
            outst_q    <= 1'b0;
            discard_q  <= 1'b0;
            skip_low_q <= RESET_PC[1];
        end else begin
            buf_q      <= buf_d;
            occ_q      <= occ_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            skip_low_q <= skip_low_d;
        end
    end

    // Overflow means the fetch throttle let too much data in.
    always_ff @(posedge risc_clk) begin
        if (!rst && !bus.redirect) begin
            assert (occ_n <= BUF_MAX);
        end
    end

    assign bus.fetch_req  = req;
    assign bus.fetch_addr = addr_q;
    assign bus.inst_valid = inst_valid;
    assign bus.inst_pc    = pc_q;
    assign bus.inst_c     = inst_valid && head_c;
    assign bus.inst_out   = !inst_valid ? NOP_INST :
                            head_c      ? {16'h0000, buf_q[0]} :
                                          {buf_q[1], buf_q[0]};

endmodule

// File: tb/tb_fetch_aligner.sv
// tb/tb_fetch_aligner.sv - scoreboard bench for fetch_aligner
module tb_fetch_aligner;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        c;
    } exp_t;

    logic clk;
    logic rst;
    fetch_aligner_if bus();

    fetch_aligner #(.RESET_PC(32'h0000_0000), .BUF_HW(4)) dut (
        .risc_clk (clk),
        .rst      (rst),
        .bus      (bus)
    );

    exp_t        exp_q[$];
    logic [31:0] req_log[$];
    logic [31:0] mem [256];
    int          lat;
    int          cyc;
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_due;
    int          n_checks;
    int          n_pass;
    int          n_fail;
    int          n_cons;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] inst, input logic [31:0] pc, input logic c);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        e.c    = c;
        exp_q.push_back(e);
    endtask

    task automatic push_nops(input logic [31:0] start, input int count);
        for (int k = 0; k < count; k++) push_exp(32'h0000_0013, start + 32'(4 * k), 1'b0);
    endtask

    task automatic wait_cons(input int target, input string tag);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (n_cons < target && t < 300);
        check(tag, 32'(n_cons >= target), 32'd1);
    endtask

    task automatic wait_pend(input logic [31:0] addr, input string tag);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(pend && pend_addr == addr) && t < 300);
        check(tag, 32'(pend && pend_addr == addr), 32'd1);
    endtask

    task automatic load_mixed();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        mem[0] = 32'h0093_4505;
        mem[1] = 32'h4585_0050;
    endtask

    task automatic push_mixed();
        push_exp(32'h0000_4505, 32'h0, 1'b1);
        push_exp(32'h0050_0093, 32'h2, 1'b0);
        push_exp(32'h0000_4585, 32'h6, 1'b1);
        push_nops(32'h8, 16);
    endtask

    // Instruction memory: one response per request after 'lat' cycles.
    initial begin
        bus.fetch_valid = 1'b0;
        bus.fetch_data  = 32'h0;
        pend      = 1'b0;
        pend_addr = 32'h0;
        pend_due  = 0;
        cyc       = 0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.fetch_valid = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else if (pend && cyc >= pend_due) begin
                bus.fetch_valid = 1'b1;
                bus.fetch_data  = mem[pend_addr[9:2]];
                pend = 1'b0;
            end
            #1;
            if (bus.fetch_req) begin
                pend      = 1'b1;
                pend_addr = bus.fetch_addr;
                pend_due  = cyc + lat;
                req_log.push_back(bus.fetch_addr);
            end
        end
    end

    // Scoreboard: every accepted instruction is compared with the oldest expectation.
    initial begin
        exp_t e;
        n_cons = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.inst_valid && bus.inst_ready && !bus.redirect) begin
                n_cons++;
                check("scoreboard_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("inst_out", bus.inst_out, e.inst);
                    check("inst_pc", bus.inst_pc, e.pc);
                    check("inst_c", 32'(bus.inst_c), 32'(e.c));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int base;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        lat      = 1;
        rst      = 1'b1;
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_fetch_req", 32'(bus.fetch_req), 32'd0);
        check("rst_inst_out", bus.inst_out, 32'h0000_0013);
        check("rst_inst_pc", bus.inst_pc, 32'h0);
        check("rst_inst_c", 32'(bus.inst_c), 32'd0);
        check("rst_fetch_addr", bus.fetch_addr, 32'h0);

        // Aligned 32-bit stream, 1-cycle latency, no bubbles
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        push_exp(32'h0050_0093, 32'h0, 1'b0);
        push_exp(32'h0010_0113, 32'h4, 1'b0);
        push_nops(32'h8, 14);
        @(negedge clk);
        rst = 1'b0;
        bus.inst_ready = 1'b1;
        #1;
        check("release_fetch_req", 32'(bus.fetch_req), 32'd1);
        check("release_fetch_addr", bus.fetch_addr, 32'h0);
        wait_cons(1, "aligned_first");
        base = n_cons;
        repeat (8) @(negedge clk);
        check("aligned_throughput", 32'(n_cons - base), 32'd8);
        bus.inst_ready = 1'b0;

        // Mixed compressed / straddling stream
        rst = 1'b1;
        load_mixed();
        repeat (2) @(negedge clk);
        exp_q.delete();
        push_mixed();
        rst = 1'b0;
        bus.inst_ready = 1'b1;

        // Stall with the instruction at pc 8 on the output
        begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(bus.inst_valid && bus.inst_pc == 32'h8) && t < 300);
            bus.inst_ready = 1'b0;
            check("stall_reached_pc8", bus.inst_pc, 32'h8);
        end
        for (int s = 0; s < 5; s++) begin
            #1;
            check("stall_inst_valid", 32'(bus.inst_valid), 32'd1);
            check("stall_inst_out", bus.inst_out, 32'h0000_0013);
            check("stall_inst_pc", bus.inst_pc, 32'h8);
            check("stall_inst_c", 32'(bus.inst_c), 32'd0);
            if (s >= 1) check("stall_fetch_req", 32'(bus.fetch_req), 32'd0);
            @(negedge clk);
        end
        bus.inst_ready = 1'b1;
        base = n_cons;
        wait_cons(base + 8, "stall_release");
        bus.inst_ready = 1'b0;

        // Redirect while the request to 0x10 is in flight
        rst = 1'b1;
        lat = 3;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        mem[8'h40] = 32'h4505_FFFF;
        mem[8'h41] = 32'h0050_0093;
        repeat (2) @(negedge clk);
        exp_q.delete();
        push_nops(32'h0, 4);
        rst = 1'b0;
        bus.inst_ready = 1'b1;
        wait_pend(32'h10, "redirect_req10_seen");
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0102;
        bus.inst_ready  = 1'b0;
        exp_q.delete();
        req_log.delete();
        push_exp(32'h0000_4505, 32'h102, 1'b1);
        push_exp(32'h0050_0093, 32'h104, 1'b0);
        push_nops(32'h108, 12);
        @(negedge clk);
        bus.redirect   = 1'b0;
        bus.inst_ready = 1'b1;
        #1;
        check("redir_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("redir_inst_pc", bus.inst_pc, 32'h102);
        check("redir_fetch_addr", bus.fetch_addr, 32'h100);
        check("redir_fetch_req", 32'(bus.fetch_req), 32'd0);
        base = n_cons;
        wait_cons(base + 4, "redir_stream");
        check("redir_log_nonempty", 32'(req_log.size() != 0), 32'd1);
        if (req_log.size() != 0) check("redir_first_req", req_log[0], 32'h100);
        bus.inst_ready = 1'b0;

        // Reset pulse during a straddled fetch
        rst = 1'b1;
        lat = 2;
        load_mixed();
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        bus.inst_ready = 1'b1;
        wait_pend(32'h4, "midrst_req4_seen");
        rst = 1'b1;
        #1;
        check("midrst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("midrst_fetch_req", 32'(bus.fetch_req), 32'd0);
        check("midrst_inst_out", bus.inst_out, 32'h0000_0013);
        check("midrst_inst_pc", bus.inst_pc, 32'h0);
        check("midrst_inst_c", 32'(bus.inst_c), 32'd0);
        check("midrst_fetch_addr", bus.fetch_addr, 32'h0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        req_log.delete();
        push_mixed();
        rst = 1'b0;
        base = n_cons;
        wait_cons(base + 4, "midrst_restart");
        check("midrst_log_nonempty", 32'(req_log.size() != 0), 32'd1);
        if (req_log.size() != 0) check("midrst_first_req", req_log[0], 32'h0);
        bus.inst_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
